// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the control unit and its instruction decoder.
//   - opcode constants, as they appear in IR[31:27]
//   - ALU operation select codes driven on CONTROL
//   - control-unit state encoding (also exported on the State debug port)
//   - instruction class used to steer the T3..T6 sequence
package cpu_pkg;

   // Opcodes (IR[31:27])
   localparam logic [4:0] OpAdd  = 5'b00011;
   localparam logic [4:0] OpSub  = 5'b00100;
   localparam logic [4:0] OpShr  = 5'b00101;
   localparam logic [4:0] OpShl  = 5'b00110;
   localparam logic [4:0] OpRor  = 5'b00111;
   localparam logic [4:0] OpRol  = 5'b01000;
   localparam logic [4:0] OpAnd  = 5'b01001;
   localparam logic [4:0] OpOr   = 5'b01010;
   localparam logic [4:0] OpMul  = 5'b01111;
   localparam logic [4:0] OpDiv  = 5'b10000;
   localparam logic [4:0] OpNop  = 5'b11010;
   localparam logic [4:0] OpHalt = 5'b11011;

   // ALU operation select codes
   localparam logic [3:0] CtlAnd = 4'd0;
   localparam logic [3:0] CtlOr  = 4'd1;
   localparam logic [3:0] CtlAdd = 4'd2;
   localparam logic [3:0] CtlSub = 4'd3;
   localparam logic [3:0] CtlShr = 4'd4;
   localparam logic [3:0] CtlShl = 4'd5;
   localparam logic [3:0] CtlRor = 4'd6;
   localparam logic [3:0] CtlRol = 4'd7;
   localparam logic [3:0] CtlMul = 4'd8;
   localparam logic [3:0] CtlDiv = 4'd9;

   // Control-unit states; the numeric values are visible on the State port.
   typedef enum logic [3:0] {
      StIdle = 4'd0,
      StT0   = 4'd1,
      StT1   = 4'd2,
      StT2   = 4'd3,
      StT3   = 4'd4,
      StT4   = 4'd5,
      StT5   = 4'd6,
      StT6   = 4'd7,
      StHalt = 4'd8
   } state_e;

   // Instruction classes
   typedef enum logic [2:0] {
      ClsAlu     = 3'd0,
      ClsMulDiv  = 3'd1,
      ClsNop     = 3'd2,
      ClsHalt    = 3'd3,
      ClsIllegal = 3'd4
   } op_class_e;

endpackage

// File: rtl/ir_decode.sv
// ir_decode: purely combinational instruction field extractor and classifier.
// Ports:
//   ir_i        instruction word
//   opcode_o    IR[31:27]
//   ra_o        IR[26:23]
//   rb_o        IR[22:19]
//   rc_o        IR[18:15]
//   op_class_o  ALU, MUL/DIV, NOP, HALT or illegal
//   control_o   ALU operation select (0 for anything that is not ALU/MUL/DIV)
module ir_decode
   import cpu_pkg::*;
(
   input  logic [31:0] ir_i,
   output logic [4:0]  opcode_o,
   output logic [3:0]  ra_o,
   output logic [3:0]  rb_o,
   output logic [3:0]  rc_o,
   output op_class_e   op_class_o,
   output logic [3:0]  control_o
);

   logic [4:0] opcode;

   assign opcode   = ir_i[31:27];
   assign opcode_o = opcode;
   assign ra_o     = ir_i[26:23];
   assign rb_o     = ir_i[22:19];
   assign rc_o     = ir_i[18:15];

   always_comb begin
      op_class_o = ClsIllegal;
      control_o  = CtlAnd;
      case (opcode)
         OpAnd:  begin op_class_o = ClsAlu;    control_o = CtlAnd; end
         OpOr:   begin op_class_o = ClsAlu;    control_o = CtlOr;  end
         OpAdd:  begin op_class_o = ClsAlu;    control_o = CtlAdd; end
         OpSub:  begin op_class_o = ClsAlu;    control_o = CtlSub; end
         OpShr:  begin op_class_o = ClsAlu;    control_o = CtlShr; end
         OpShl:  begin op_class_o = ClsAlu;    control_o = CtlShl; end
         OpRor:  begin op_class_o = ClsAlu;    control_o = CtlRor; end
         OpRol:  begin op_class_o = ClsAlu;    control_o = CtlRol; end
         OpMul:  begin op_class_o = ClsMulDiv; control_o = CtlMul; end
         OpDiv:  begin op_class_o = ClsMulDiv; control_o = CtlDiv; end
         OpNop:  op_class_o = ClsNop;
         OpHalt: op_class_o = ClsHalt;
         default: op_class_o = ClsIllegal;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired sequencer for the datapath.
// Sequence: IDLE -> T0 (fetch addr) -> T1 (memory read, waits on MemReady)
//           -> T2 (load IR) -> T3..T6 (execute) -> T0 or IDLE; HALT parks the unit.
// Ports:
//   Clock, Clear      clock, synchronous active-high reset
//   Run               permits leaving IDLE / restarting from HALT
//   IR                instruction register contents
//   MemReady          memory data valid this cycle
//   PCout..lowin      datapath strobes
//   Rin, Rout         one-hot general register load/drive selects
//   CONTROL           ALU operation select
//   Halted            high while in HALT
//   State             current state encoding (debug)
module control_unit
   import cpu_pkg::*;
#(
   parameter int unsigned NREGS = 16
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             Run,
   input  logic [31:0]      IR,
   input  logic             MemReady,
   output logic             PCout,
   output logic             Zhighout,
   output logic             Zlowout,
   output logic             MDRout,
   output logic             MARin,
   output logic             PCin,
   output logic             MDRin,
   output logic             IRin,
   output logic             Yin,
   output logic             IncPC,
   output logic             Read,
   output logic             Zhighin,
   output logic             Zlowin,
   output logic             highin,
   output logic             lowin,
   output logic [NREGS-1:0] Rin,
   output logic [NREGS-1:0] Rout,
   output logic [3:0]       CONTROL,
   output logic             Halted,
   output logic [3:0]       State
);

   state_e      state_q, state_d;
   logic [31:0] ir_q;
   logic        run_low_q, run_low_d;

   logic [31:0] ir_cur;
   logic [4:0]  opcode;
   logic [3:0]  ra, rb, rc;
   op_class_e   op_class;
   logic [3:0]  alu_ctl;
   logic [3:0]  src_a, src_b;
   logic        is_muldiv;

   logic        rin_en, rout_en;
   logic [3:0]  rin_idx, rout_idx;

   // The IR register is loaded at the end of T2, so it is first valid in T3.
   // Capture it there so T4..T6 keep decoding the same instruction.
   assign ir_cur = (state_q == StT3) ? IR : ir_q;

   ir_decode u_ir_decode (
      .ir_i       (ir_cur),
      .opcode_o   (opcode),
      .ra_o       (ra),
      .rb_o       (rb),
      .rc_o       (rc),
      .op_class_o (op_class),
      .control_o  (alu_ctl)
   );

   assign is_muldiv = (op_class == ClsMulDiv);
   // MUL/DIV have no destination field: their operands sit in the Ra/Rb fields.
   assign src_a     = is_muldiv ? ra : rb;
   assign src_b     = is_muldiv ? rb : rc;

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q   <= StIdle;
         ir_q      <= '0;
         run_low_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_low_q <= run_low_d;
         if (state_q == StT3) begin
            ir_q <= IR;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      run_low_d = 1'b0;
      PCout     = 1'b0;
      Zhighout  = 1'b0;
      Zlowout   = 1'b0;
      MDRout    = 1'b0;
      MARin     = 1'b0;
      PCin      = 1'b0;
      MDRin     = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      IncPC     = 1'b0;
      Read      = 1'b0;
      Zhighin   = 1'b0;
      Zlowin    = 1'b0;
      highin    = 1'b0;
      lowin     = 1'b0;
      CONTROL   = 4'd0;
      rin_en    = 1'b0;
      rout_en   = 1'b0;
      rin_idx   = 4'd0;
      rout_idx  = 4'd0;

      case (state_q)
         StIdle: begin
            if (Run) state_d = StT0;
         end
         StT0: begin
            PCout   = 1'b1;
            MARin   = 1'b1;
            IncPC   = 1'b1;
            Zlowin  = 1'b1;
            state_d = StT1;
         end
         StT1: begin
            Read  = 1'b1;
            MDRin = 1'b1;
            // PC update only on the completing cycle, so a wait never re-loads it.
            if (MemReady) begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
               state_d = StT2;
            end
         end
         StT2: begin
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = StT3;
         end
         StT3: begin
            case (op_class)
               ClsAlu, ClsMulDiv: begin
                  rout_en  = 1'b1;
                  rout_idx = src_a;
                  Yin      = 1'b1;
                  state_d  = StT4;
               end
               ClsHalt: state_d = StHalt;
               default: state_d = Run ? StT0 : StIdle;
            endcase
         end
         StT4: begin
            rout_en  = 1'b1;
            rout_idx = src_b;
            CONTROL  = alu_ctl;
            Zlowin   = 1'b1;
            Zhighin  = is_muldiv;
            state_d  = StT5;
         end
         StT5: begin
            Zlowout = 1'b1;
            if (is_muldiv) begin
               lowin   = 1'b1;
               state_d = StT6;
            end else begin
               rin_en  = 1'b1;
               rin_idx = ra;
               state_d = Run ? StT0 : StIdle;
            end
         end
         StT6: begin
            Zhighout = 1'b1;
            highin   = 1'b1;
            state_d  = Run ? StT0 : StIdle;
         end
         StHalt: begin
            // Restart needs Run to have been seen low first; a stuck-high Run stays halted.
            run_low_d = run_low_q | ~Run;
            if (run_low_q && Run) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // One-hot register selects; an index beyond NREGS-1 selects nothing.
   always_comb begin
      Rin  = '0;
      Rout = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         Rin[i]  = rin_en  && (32'(rin_idx)  == i);
         Rout[i] = rout_en && (32'(rout_idx) == i);
      end
   end

   assign Halted = (state_q == StHalt);
   assign State  = state_q;

   logic unused_opcode;
   assign unused_opcode = ^opcode;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter NREGS, default 16, number of general registers driven by the one-hot select vectors.
REQ-002 Clock  input  1  single clock; all state changes on rising edge.
REQ-003 Clear  input  1  reset, synchronous, active-high.
REQ-004 Run  input  1  level; permits leaving IDLE and HALT-to-IDLE restart.
REQ-005 IR  input  32  instruction register contents: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-006 MemReady  input  1  memory data valid on Mdatain this cycle.
REQ-007 PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Zhighin, Zlowin, highin, lowin  output  1 each  datapath strobes, same meaning as datapath ports.
REQ-008 Rin  output  NREGS  one-hot register load; bit i drives Ri-in.
REQ-009 Rout  output  NREGS  one-hot register drive; bit i drives Ri-out.
REQ-010 CONTROL  output  4  ALU operation select.
REQ-011 Halted  output  1  high while in HALT.
REQ-012 State  output  4  current state encoding, debug only.

Function
REQ-013 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; one state per clock; outputs SHALL be Moore decode of state plus latched IR, asserted for the whole cycle.
REQ-014 IDLE: all strobes 0; go T0 when Run=1, else stay.
REQ-015 T0: PCout, MARin, IncPC, Zlowin = 1; next T1.
REQ-016 T1: Zlowout, PCin, Read, MDRin = 1; stay in T1 with Read/MDRin held while MemReady=0; PCin and Zlowout asserted only in the cycle where MemReady=1; next T2.
REQ-017 T2: MDRout, IRin = 1; next T3.
REQ-018 T3 (ALU and MUL/DIV ops): Rout[Rb]=1, Yin=1; next T4.
REQ-019 T4: Rout[Rc]=1, CONTROL=op code, Zlowin=1 (MUL/DIV also Zhighin=1); next T5.
REQ-020 T5: Zlowout=1; ALU ops Rin[Ra]=1, next T0 if Run=1 else IDLE; MUL/DIV lowin=1, next T6.
REQ-021 T6 (MUL/DIV only): Zhighout=1, highin=1; next T0 if Run=1 else IDLE.
REQ-022 Opcode to CONTROL: AND 01001->0, OR 01010->1, ADD 00011->2, SUB 00100->3, SHR 00101->4, SHL 00110->5, ROR 00111->6, ROL 01000->7, MUL 01111->8, DIV 10000->9; MUL/DIV use Rb as Ra-field-free operands (IR[26:23], IR[22:19]) in T3/T4.
REQ-023 NOP 11010 and any undefined opcode: T3 SHALL go directly to T0 (Run=1) or IDLE, no strobes in T3.
REQ-024 HALT 11011: T3 SHALL go to HALT; Halted=1, no strobes; HALT to IDLE only on Run falling to 0 then Clear or Run re-asserted after being low for ≥1 cycle.
REQ-025 Latency: ALU instruction 6 cycles T0–T5 with MemReady=1 in T1; MUL/DIV 7; each MemReady=0 cycle adds 1.
REQ-026 Register select: Rin/Rout SHALL be one-hot or zero; never two bits set; register field index ≥NREGS SHALL produce zero vector.
REQ-027 Run dropping mid-instruction SHALL NOT abort; instruction completes, then IDLE.

Reset
REQ-028 Clear=1 at a rising edge SHALL force IDLE and all outputs 0 (CONTROL=0, Halted=0, State=IDLE) in the following cycle, from any state including T1 wait and HALT.
REQ-029 Clear has priority over Run and MemReady.

Structure
REQ-030 Shared package cpu_pkg SHALL hold opcode constants, CONTROL codes, and the state encoding.
REQ-031 One combinational sub-module ir_decode SHALL extract opcode/Ra/Rb/Rc, classify (ALU, MULDIV, NOP, HALT, illegal) and map CONTROL.

Verification
REQ-032 Clear 2 cycles, Run=1, IR=0x4A920000, MemReady=1 -> T0..T5 in 6 cycles, T4 CONTROL=0 Rout=bit4, T5 Rin=bit5, T3 Rout=bit2.
REQ-033 MemReady=0 for 3 cycles in T1 -> Read/MDRin held 4 cycles, PCin high exactly 1 cycle, total 9 cycles.
REQ-034 IR opcode MUL (0x78900000) -> T6 reached, T5 lowin=1, T6 highin=1 Zhighout=1, 7 cycles.
REQ-035 IR=0xD8000000 (HALT) -> HALT after T3, Halted=1, all strobes 0 for 10 cycles with Run=1.
REQ-036 Clear pulsed in T4 -> next cycle IDLE, all outputs 0, no Zlowin.
REQ-037 Run=0 during T3 of ADD -> completes T5 then IDLE, no T0.
